// File: rtl/rx_char_queue.sv
// rtl/rx_char_queue.sv - parametrised SpaceWire receive-character FIFO with level, almost-full, overrun and flush
module rx_char_queue #(
    parameter int DW       = 8,
    parameter int AW       = 3,
    parameter int AF_LEVEL = (1 << AW) - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nchar,
    input  logic          lchar,
    input  logic [DW-1:0] char_i,
    input  logic          stb_i,
    output logic          ack_o,
    output logic [DW:0]   dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic [AW:0]   level_o,
    output logic          overrun_o,
    input  logic          clr_overrun_i,
    input  logic          flush_i
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_L    = (AW + 1)'(AF_LEVEL);

    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] rp_q;
    logic [AW-1:0] wp_q;
    logic [AW:0]   level_q;
    logic          ack_q;
    logic          overrun_q;

    logic          code_ok;
    logic          valid;
    logic          push;
    logic          pop;
    logic          overflow;
    logic [DW:0]   entry;

    // Only EOP (10) and EEP (01) L-Chars reach the host; FCT/ESC are link-internal.
    assign code_ok  = (char_i[1:0] == 2'b01) || (char_i[1:0] == 2'b10);
    assign valid    = nchar | (lchar & code_ok);
    assign entry    = {lchar & ~nchar, char_i};

    assign full_o        = (level_q == DEPTH_L);
    assign empty_o       = (level_q == '0);
    assign almost_full_o = (level_q >= AF_L);
    assign level_o       = level_q;
    assign ack_o         = ack_q;
    assign overrun_o     = overrun_q;

    // A pop frees a slot on the same edge, so a push at full is allowed alongside it.
    assign pop      = ack_q & ~empty_o;
    assign push     = valid & (~full_o | pop);
    assign overflow = valid & full_o & ~pop;

    assign dat_o = mem[rp_q];

    always_ff @(posedge clk) begin
        if (!reset && !flush_i && push) begin
            mem[wp_q] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp_q      <= '0;
            wp_q      <= '0;
            level_q   <= '0;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ack_q <= stb_i;

            if (overflow) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun_i) begin
                overrun_q <= 1'b0;
            end

            if (flush_i) begin
                rp_q    <= '0;
                wp_q    <= '0;
                level_q <= '0;
            end else begin
                if (push) begin
                    wp_q <= wp_q + AW'(1);
                end
                if (pop) begin
                    rp_q <= rp_q + AW'(1);
                end
                if (push && !pop) begin
                    level_q <= level_q + (AW + 1)'(1);
                end else if (pop && !push) begin
                    level_q <= level_q - (AW + 1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_char_queue.sv
// tb/tb_rx_char_queue.sv - self-checking bench for rx_char_queue against a queue-based reference model
module tb_rx_char_queue;

    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, nchar, lchar, stb_i, clr_overrun_i, flush_i;
    logic [7:0] char_i;
    logic       ack_o, full_o, empty_o, almost_full_o, overrun_o;
    logic [8:0] dat_o;
    logic [3:0] level_o;

    logic       s_reset, s_nchar, s_lchar, s_stb, s_clr, s_flush;
    logic [3:0] s_char;
    logic       s_ack, s_full, s_empty, s_af, s_ovr;
    logic [4:0] s_dat;
    logic [1:0] s_level;

    rx_char_queue u_dut (
        .clk(clk), .reset(reset), .nchar(nchar), .lchar(lchar), .char_i(char_i),
        .stb_i(stb_i), .ack_o(ack_o), .dat_o(dat_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .level_o(level_o), .overrun_o(overrun_o),
        .clr_overrun_i(clr_overrun_i), .flush_i(flush_i)
    );

    rx_char_queue #(.DW(4), .AW(1), .AF_LEVEL(2)) u_small (
        .clk(clk), .reset(s_reset), .nchar(s_nchar), .lchar(s_lchar), .char_i(s_char),
        .stb_i(s_stb), .ack_o(s_ack), .dat_o(s_dat), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_af), .level_o(s_level), .overrun_o(s_ovr),
        .clr_overrun_i(s_clr), .flush_i(s_flush)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] mq[$];
    logic       m_ack = 1'b0;
    logic       m_ovr = 1'b0;

    task automatic model_step();
        logic       valid, full, pop;
        logic [8:0] entry;
        valid = nchar || (lchar && (char_i[1:0] == 2'b01 || char_i[1:0] == 2'b10));
        entry = {lchar && !nchar, char_i};
        full  = (mq.size() == DEPTH);
        pop   = m_ack && (mq.size() != 0);
        if (reset) begin
            mq.delete();
            m_ack = 1'b0;
            m_ovr = 1'b0;
        end else begin
            if (valid && full && !pop) m_ovr = 1'b1;
            else if (clr_overrun_i)    m_ovr = 1'b0;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (valid && (!full || pop)) mq.push_back(entry);
            end
            m_ack = stb_i;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; nchar = 0; lchar = 0; char_i = 8'h00;
        stb_i = 0; clr_overrun_i = 0; flush_i = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; nchar = 1; stb_i = 1; flush_i = 1; char_i = 8'h5A;
        tick();
        tick();
        idle();
        n_cmp++;
        if ({ack_o, empty_o, full_o, almost_full_o, overrun_o, level_o} !== {5'b01000, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b",
                     {ack_o, empty_o, full_o, almost_full_o, overrun_o, level_o}, {5'b01000, 4'd0});
        end
    endtask

    task automatic test_classification();
        logic [7:0] codes [5];
        int         exp_lvl [5];
        codes   = '{8'h55, 8'h02, 8'h01, 8'h00, 8'h03};
        exp_lvl = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            nchar  = (i == 0);
            lchar  = (i != 0);
            char_i = codes[i];
            tick();
            n_cmp++;
            if (level_o !== 4'(exp_lvl[i]) || overrun_o !== 1'b0) begin
                n_bad++;
                $display("FAIL class_level[%0d]: got level %0d ovr %b want level %0d ovr 0",
                         i, level_o, overrun_o, exp_lvl[i]);
            end
        end
        idle();
        n_cmp++;
        if (dat_o !== 9'h055) begin
            n_bad++;
            $display("FAIL class_head: got %h want 055", dat_o);
        end
    endtask

    task automatic test_fill_overrun();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            nchar = 1; char_i = 8'(i);
            tick();
            n_cmp++;
            if (level_o !== 4'(i + 1) || almost_full_o !== (i + 1 >= AF) || full_o !== (i + 1 == 8)) begin
                n_bad++;
                $display("FAIL fill[%0d]: got lvl %0d af %b full %b want lvl %0d af %b full %b",
                         i, level_o, almost_full_o, full_o, i + 1, (i + 1 >= AF), (i + 1 == 8));
            end
        end
        nchar = 1; char_i = 8'h08;
        tick();
        n_cmp++;
        if (level_o !== 4'd8 || overrun_o !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got lvl %0d ovr %b want lvl 8 ovr 1", level_o, overrun_o);
        end
        idle();
        clr_overrun_i = 1;
        tick();
        idle();
        n_cmp++;
        if (overrun_o !== 1'b0 || dat_o !== 9'h000) begin
            n_bad++;
            $display("FAIL overrun_clr: got ovr %b dat %h want ovr 0 dat 000", overrun_o, dat_o);
        end
    endtask

    task automatic test_drain();
        idle();
        stb_i = 1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_cmp++;
            if (ack_o !== 1'b1) begin
                n_bad++;
                $display("FAIL drain_ack[%0d]: got %b want 1", k, ack_o);
            end
            if (k <= 8) begin
                n_cmp++;
                if (dat_o !== 9'(k - 1) || level_o !== 4'(9 - k)) begin
                    n_bad++;
                    $display("FAIL drain_dat[%0d]: got dat %h lvl %0d want dat %h lvl %0d",
                             k, dat_o, level_o, 9'(k - 1), 9 - k);
                end
            end else begin
                n_cmp++;
                if (empty_o !== 1'b1 || level_o !== 4'd0) begin
                    n_bad++;
                    $display("FAIL drain_empty: got empty %b lvl %0d want 1 0", empty_o, level_o);
                end
            end
        end
        idle();
        tick();
        n_cmp++;
        if (ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_ack_drop: got %b want 0", ack_o);
        end
        nchar = 1; char_i = 8'h3C;
        tick();
        idle();
        n_cmp++;
        if (dat_o !== 9'h03C || level_o !== 4'd1) begin
            n_bad++;
            $display("FAIL underflow_rp: got dat %h lvl %0d want 03c 1", dat_o, level_o);
        end
    endtask

    task automatic test_concurrent_full();
        do_reset();
        lchar = 1; char_i = 8'h02;
        repeat (8) tick();
        idle();
        n_cmp++;
        if (full_o !== 1'b1 || dat_o !== 9'h102) begin
            n_bad++;
            $display("FAIL conc_fill: got full %b dat %h want 1 102", full_o, dat_o);
        end
        stb_i = 1; nchar = 1; char_i = 8'hAA;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_cmp++;
            if (level_o !== 4'd8) begin
                n_bad++;
                $display("FAIL conc_level[%0d]: got %0d want 8", k, level_o);
            end
            if (k >= 2) begin
                n_cmp++;
                if (dat_o !== ((k == 9) ? 9'h0AA : 9'h102)) begin
                    n_bad++;
                    $display("FAIL conc_dat[%0d]: got %h want %h", k, dat_o, (k == 9) ? 9'h0AA : 9'h102);
                end
            end
        end
        idle();
        tick();
        n_cmp++;
        if (level_o !== 4'd7 || dat_o !== 9'h0AA) begin
            n_bad++;
            $display("FAIL conc_release: got lvl %0d dat %h want 7 0aa", level_o, dat_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            nchar = 1; char_i = 8'(8'h10 + i);
            tick();
        end
        idle();
        stb_i = 1;
        repeat (3) tick();
        idle();
        tick();
        n_cmp++;
        if (level_o !== 4'd5 || overrun_o !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_pre: got lvl %0d ovr %b want 5 1", level_o, overrun_o);
        end
        flush_i = 1; nchar = 1; char_i = 8'h77; stb_i = 1;
        tick();
        idle();
        n_cmp++;
        if ({level_o, empty_o, overrun_o, ack_o} !== {4'd0, 3'b111}) begin
            n_bad++;
            $display("FAIL flush_post: got lvl %0d empty %b ovr %b ack %b want 0 1 1 1",
                     level_o, empty_o, overrun_o, ack_o);
        end
        tick();
        nchar = 1; char_i = 8'h66;
        tick();
        idle();
        n_cmp++;
        if (dat_o !== 9'h066 || level_o !== 4'd1) begin
            n_bad++;
            $display("FAIL flush_ptrs: got dat %h lvl %0d want 066 1", dat_o, level_o);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_st;
        logic [8:0] got_st;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            flush_i       = ($urandom_range(0, 79) == 0);
            clr_overrun_i = ($urandom_range(0, 7) == 0);
            nchar         = ($urandom_range(0, 2) == 0);
            lchar         = ($urandom_range(0, 2) == 0);
            char_i        = 8'($urandom);
            stb_i         = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
            exp_st = {m_ack, mq.size() == 0, mq.size() == DEPTH, mq.size() >= AF, m_ovr, 4'(mq.size())};
            got_st = {ack_o, empty_o, full_o, almost_full_o, overrun_o, level_o};
            n_cmp++;
            if (got_st !== exp_st) begin
                n_bad++;
                $display("FAIL rand_status[%0d]: got %b want %b", c, got_st, exp_st);
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (dat_o !== mq[0]) begin
                    n_bad++;
                    $display("FAIL rand_dat[%0d]: got %h want %h", c, dat_o, mq[0]);
                end
            end
        end
        idle();
    endtask

    task automatic test_small_params();
        s_reset = 1; s_nchar = 0; s_lchar = 0; s_char = 4'h0; s_stb = 0; s_clr = 0; s_flush = 0;
        tick();
        s_reset = 0;
        n_cmp++;
        if (s_level !== 2'd0 || s_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL small_reset: got lvl %0d empty %b want 0 1", s_level, s_empty);
        end
        s_nchar = 1; s_char = 4'h3;
        tick();
        n_cmp++;
        if ({s_level, s_full, s_af} !== {2'd1, 2'b00}) begin
            n_bad++;
            $display("FAIL small_one: got lvl %0d full %b af %b want 1 0 0", s_level, s_full, s_af);
        end
        s_char = 4'hC;
        tick();
        n_cmp++;
        if ({s_level, s_full, s_af} !== {2'd2, 2'b11}) begin
            n_bad++;
            $display("FAIL small_full: got lvl %0d full %b af %b want 2 1 1", s_level, s_full, s_af);
        end
        s_nchar = 0; s_stb = 1;
        tick();
        n_cmp++;
        if (s_ack !== 1'b1 || s_dat !== 5'h03 || s_level !== 2'd2) begin
            n_bad++;
            $display("FAIL small_ack: got ack %b dat %h lvl %0d want 1 03 2", s_ack, s_dat, s_level);
        end
        s_nchar = 1; s_char = 4'h9;
        tick();
        n_cmp++;
        if (s_dat !== 5'h0C || s_level !== 2'd2) begin
            n_bad++;
            $display("FAIL small_wrap1: got dat %h lvl %0d want 0c 2", s_dat, s_level);
        end
        s_nchar = 0; s_lchar = 1; s_char = 4'h6;
        tick();
        n_cmp++;
        if (s_dat !== 5'h09) begin
            n_bad++;
            $display("FAIL small_wrap2: got dat %h want 09", s_dat);
        end
        s_lchar = 0; s_nchar = 1; s_char = 4'hF;
        tick();
        n_cmp++;
        if (s_dat !== 5'h16) begin
            n_bad++;
            $display("FAIL small_lchar: got dat %h want 16", s_dat);
        end
        s_nchar = 0; s_stb = 0;
        tick();
        n_cmp++;
        if ({s_level, s_dat, s_full, s_af, s_ack, s_ovr} !== {2'd1, 5'h0F, 4'b0000}) begin
            n_bad++;
            $display("FAIL small_tail: got lvl %0d dat %h full %b af %b ack %b ovr %b want 1 0f 0 0 0 0",
                     s_level, s_dat, s_full, s_af, s_ack, s_ovr);
        end
    endtask

    initial begin
        s_reset = 1; s_nchar = 0; s_lchar = 0; s_char = 4'h0; s_stb = 0; s_clr = 0; s_flush = 0;
        idle();
        test_reset();
        test_classification();
        test_fill_overrun();
        test_drain();
        test_concurrent_full();
        test_flush();
        test_random();
        test_small_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_char_queue.md
# rx_char_queue

Parametrised receive-character FIFO for the SpaceWire link layer, the next generation of the fixed 8-deep, 9-bit receive queue. It sits between the receiver's character decoder and the host-side Wishbone B4 pipelined read port. It accepts N-Chars and EOP/EEP L-Chars, discards FCT/ESC, and supports concurrent push/pop at full. Over the fixed queue it adds configurable width and depth, a level counter, an almost-full threshold, a sticky overrun flag and a synchronous flush.

## Interface
- `DW`, 8: character payload width; stored entry width is DW+1. Must be ≥ 2.
- `AW`, 3: log2 of depth; DEPTH = 2^AW. Must be ≥ 1.
- `AF_LEVEL`, DEPTH-2: almost-full threshold, in range 1..DEPTH.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `nchar`  in  1  decoder presents an N-Char on `char_i` this cycle.
- `lchar`  in  1  decoder presents an L-Char; control code in `char_i[1:0]`.
- `char_i`  in  DW  character payload.
- `stb_i`  in  1  Wishbone pipelined read strobe.
- `ack_o`  out  1  read acknowledge; `dat_o` valid while high.
- `dat_o`  out  DW+1  {is_lchar, payload} at read pointer.
- `full_o`  out  1  level == DEPTH.
- `empty_o`  out  1  level == 0.
- `almost_full_o`  out  1  level ≥ AF_LEVEL.
- `level_o`  out  AW+1  number of occupied entries, 0..DEPTH.
- `overrun_o`  out  1  sticky: an accepted-class character was dropped.
- `clr_overrun_i`  in  1  clears `overrun_o`.
- `flush_i`  in  1  synchronous discard of all contents.

## Operation
- Character classification:
  - valid = nchar | (lchar & char_i[1:0] ∈ {2'b01 EEP, 2'b10 EOP}).
  - FCT (00) and ESC (11) L-Chars are never stored and never count as overrun.
  - nchar and lchar are never asserted together; if they are, nchar wins.
- Entry stored = {lchar & ~nchar, char_i}.
- pop = ack_o & ~empty_o.
- push = valid & (~full_o | pop). A push at full is permitted only when a pop occurs on the same edge.
- On push: mem[wp] ← entry; wp ← wp+1 mod DEPTH.
- On pop: rp ← rp+1 mod DEPTH.
- level_o update per edge:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on both or neither.
- Overrun:
  - valid & full_o & ~pop sets overrun_o next edge; the character is dropped with no state change.
  - clr_overrun_i clears it. Set wins if both occur on the same edge.
- flush_i:
  - Next edge: rp, wp and level are 0; overrun_o is unaffected; ack_o still follows stb_i.
  - Any push or pop on that edge is discarded.
- Read port:
  - ack_o ← stb_i every edge, independent of empty.
  - dat_o = mem[rp] combinationally.
  - An ack while empty returns undefined data and does not move rp (underflow is benign).
- Memory array is not reset. dat_o is undefined until the slot at rp has been written.

## Timing
- Reset values: ack_o=0, empty_o=1, full_o=0, almost_full_o=0, level_o=0, overrun_o=0, rp=wp=0. Reset overrides flush and all traffic.
- Write latency: character presented in cycle n is readable at rp from edge n+1. empty_o deasserts after edge n.
- Read: stb_i high at edge n gives ack_o high after edge n. rp advances at edge n+1 only if ack_o was high there and the FIFO was non-empty. Back-to-back strobes give one entry per cycle.
- Status outputs are registered or derived from registered level. They reflect state after the last edge, never same-cycle inputs.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble. Full is distinguished from empty by level, not pointer equality.
- Mid-operation reset: any in-flight ack is dropped (ack_o=0 after the reset edge) and contents are lost.

## Test plan
- Classification, default params: after reset, drive nchar; lchar with char_i 8'h02, 8'h01, 8'h00, 8'h03 -> level_o 1,2,3,3,3. overrun_o stays 0.
- Fill and overrun: push 8 N-Chars 8'h00..8'h07 -> full_o=1, level_o=8, almost_full_o set once level reaches 6. A 9th push -> level_o stays 8, overrun_o=1. clr_overrun_i -> overrun_o=0.
- Pipelined drain: stb_i held 9 cycles on a full queue -> ack_o first high after edge 1; dat_o sequence 9'h000..9'h007. rp reaches 0 and empty_o=1; the 9th ack leaves rp unchanged.
- Concurrent at full: queue full of L-Char EOP (9'h102); stb_i and nchar with 8'hAA held 9 cycles -> level_o=8 throughout, wp tracks rp. The 9th ack shows 9'h0AA; dropping both inputs pops once -> level_o=7.
- Flush: level 5, overrun_o=1; assert flush_i with push and stb_i -> after the edge level_o=0, empty_o=1, overrun_o=1.
- Parameter sweep: AW=1, DW=4, AF_LEVEL=2 -> 2-deep wrap, full_o after 2 pushes, almost_full_o at 2, dat_o width 5.
